uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving the clock cycles per serial bit (legal range 4..65535).
REQ-002 The block SHALL have parameter STOP_BITS, default 1, giving the number of stop bits per frame (legal values 1 or 2).
REQ-003 The block SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port valid_in  input  1  data_in holds a byte to send.
REQ-006 The block SHALL have port ready_out  output  1  transmitter can accept a byte this cycle.
REQ-007 The block SHALL have port data_in  input  8  byte to transmit.
REQ-008 The block SHALL have port tx  output  1  serial line, idle high.

Function
REQ-009 The block SHALL accept a byte on a rising clk edge where valid_in and ready_out are both 1, capturing data_in into an internal shift register.
REQ-010 The block SHALL ignore data_in and valid_in while ready_out is 0, so no second acceptance occurs in that window.
REQ-011 The block SHALL use FSM states IDLE, START, DATA, PARITY (macro only), STOP; transitions IDLE->START on accept, START->DATA, DATA->PARITY/STOP after bit 7, STOP->IDLE after STOP_BITS periods.
REQ-012 The block SHALL drive tx registered: 1 in IDLE, 0 in START, data bits LSB first in DATA, 1 in STOP.
REQ-013 The block SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that restarts at each bit boundary.
REQ-014 The block SHALL drive tx low on the first cycle after the accepting edge (latency 1 clock).
REQ-015 The block SHALL hold ready_out at 1 only in IDLE, deasserted from the cycle after acceptance until the last stop period completes.
REQ-016 The block SHALL return to IDLE with ready_out=1 on the cycle after the final stop cycle; back-to-back frames are therefore separated by exactly 1 idle-high cycle when valid_in is held high.
REQ-017 The block SHALL use a 3-bit data bit index that counts 0..7 with no wrap beyond 7, and a bit-period counter wide enough for CLKS_PER_BIT-1.

Reset
REQ-018 Asserting rst SHALL immediately set tx=1, ready_out=0, FSM=IDLE, and clear all counters and the shift register, including mid-frame.
REQ-019 The block SHALL assert ready_out on the first rising clk edge after rst deasserts.

Configuration
REQ-020 With macro UART_TX_PARITY_EN defined, the block SHALL insert one even-parity bit (XOR of the 8 data bits) after bit 7, lasting CLKS_PER_BIT cycles.
REQ-021 Without UART_TX_PARITY_EN, the block SHALL omit the PARITY state, going DATA->STOP directly, and the frame SHALL be 1+8+STOP_BITS bits.

Structure
REQ-022 Package uart_pkg SHALL hold the FSM state enum typedef, the default CLKS_PER_BIT constant (16) and the data width constant (8), shared with uart_rx.
REQ-023 Sub-module uart_baud_gen SHALL provide the bit-period counter with a restart input and a one-cycle bit_done pulse.

Verification
REQ-024 Bench SHALL check: reset, then send 0xA5 -> tx reads 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles (160 ns at 100 MHz), ready_out=0 throughout.
REQ-025 Bench SHALL check: valid_in held high with 0x00 then 0xFF -> two complete frames, exactly 1 idle-high cycle between them, no third acceptance.
REQ-026 Bench SHALL check: rst asserted during data bit 3 of 0x5A -> tx=1 and ready_out=0 in the same cycle; ready_out=1 one edge after release; no residual bits appear.
REQ-027 Bench SHALL check: data_in changed from 0x3C to 0xC3 one cycle after acceptance -> line still carries 0x3C.
REQ-028 Bench SHALL check: with UART_TX_PARITY_EN, 0xA5 -> parity bit 0, and 0x07 -> parity bit 1, each in bit slot 9.
REQ-029 Bench SHALL check: loopback tx into uart_rx with CLKS_PER_BIT=16 for 0x00, 0x55, 0xFF -> uart_rx pulses valid_out with matching data_out for each.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_tx and uart_rx.
//   DATA_W           : bits per character
//   CLKS_PER_BIT_DEF : default clock cycles per serial bit
//   uart_state_e     : frame FSM states. PARITY is used only when the
//                      parity option is compiled in.
//   even_parity()    : XOR of all data bits
package uart_pkg;

  localparam int DATA_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the UART.
// Counts 0..CLKS_PER_BIT-1 and pulses o_bit_done for one cycle on the last
// count of each bit period, then wraps to 0 so the next bit starts at once.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst      : asynchronous active-high reset
//   i_restart  : hold the counter at 0 (used while the line is idle)
//   o_bit_done : one-cycle pulse at the end of each bit period
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Restart wins so no stray bit_done can escape while idle.
  assign o_bit_done = !i_restart && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_restart || o_bit_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity,
// STOP_BITS stop bits. A byte is accepted on a rising edge where valid_in and
// ready_out are both high; tx goes low on the following cycle.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// after data bit 7.
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (4..65535)
//   STOP_BITS    : 1 or 2
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   valid_in  : data_in holds a byte to send
//   ready_out : transmitter can accept a byte this cycle (high only in IDLE)
//   data_in   : byte to transmit
//   tx        : registered serial output, idle high
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx
);

  // Index of the last stop period (0 for one stop bit, 1 for two).
  localparam logic STOP_LAST = (STOP_BITS == 2);

  uart_state_e       r_state;
  uart_state_e       w_state_next;
  logic              r_tx;
  logic              w_tx_next;
  logic              r_ready;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_idx_next;
  logic              r_stop_idx;
  logic              w_stop_idx_next;
  logic              w_accept;
  logic              w_bit_done;
  logic              w_restart;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  assign w_accept  = valid_in && r_ready;
  assign w_restart = (r_state == IDLE);
  assign ready_out = r_ready;
  assign tx        = r_tx;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_restart (w_restart),
    .o_bit_done(w_bit_done)
  );

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_idx_next  = r_bit_idx;
    w_stop_idx_next = r_stop_idx;
    w_tx_next       = 1'b1;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next    = START;
          w_shift_next    = data_in;
          w_bit_idx_next  = 3'd0;
          w_stop_idx_next = 1'b0;
        end
      end
      START: begin
        if (w_bit_done) w_state_next = DATA;
      end
      DATA: begin
        if (w_bit_done) begin
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end else begin
            // Shift so the next data bit is always at position 0.
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_shift_next   = {1'b0, r_shift[DATA_W-1:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_done) w_state_next = STOP;
      end
`endif
      STOP: begin
        if (w_bit_done) begin
          if (r_stop_idx == STOP_LAST) begin
            w_state_next = IDLE;
          end else begin
            w_stop_idx_next = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    // tx is registered, so it is decoded from the state being entered.
    case (w_state_next)
      IDLE:    w_tx_next = 1'b1;
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_next = r_parity;
`endif
      STOP:    w_tx_next = 1'b1;
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx       <= 1'b1;
      r_ready    <= 1'b0;
      r_shift    <= '0;
      r_bit_idx  <= 3'd0;
      r_stop_idx <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tx       <= w_tx_next;
      r_ready    <= (w_state_next == IDLE);
      r_shift    <= w_shift_next;
      r_bit_idx  <= w_bit_idx_next;
      r_stop_idx <= w_stop_idx_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the byte at acceptance since the shift register
  // loses the data as it is sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= even_parity(data_in);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int CLKS = 16;
  localparam int SB   = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB   = 1;
`else
  localparam int PB   = 0;
`endif
  localparam int NB   = 1 + 8 + PB + SB;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] data_in;
  logic       tx;

  int n_chk;
  int n_fail;

  uart_tx #(
    .CLKS_PER_BIT(CLKS),
    .STOP_BITS   (SB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .data_in  (data_in),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected line levels per bit slot, slot 0 first.
  function automatic logic [11:0] build_frame(input logic [7:0] b);
    logic [11:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  // Returns at a negedge with ready_out high, or flags a timeout.
  task automatic wait_ready();
    int n;
    n = 0;
    while (ready_out !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("ready_timeout", 0, 1);
  endtask

  // Presents b, lets it be accepted, returns at the negedge just after the
  // accepting edge. With hold=1 valid_in stays high.
  task automatic start_tx(input logic [7:0] b, input bit hold);
    wait_ready();
    data_in  = b;
    valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) valid_in = 1'b0;
  endtask

  // Starting at the first negedge after acceptance, checks every cycle of
  // every slot and ready_out low throughout; returns at the first idle negedge.
  task automatic capture(input logic [11:0] fr, input string tag, output logic [11:0] mid);
    int ok;
    int busy;
    busy = 0;
    mid  = '1;
    for (int s = 0; s < NB; s++) begin
      ok = 0;
      for (int c = 0; c < CLKS; c++) begin
        if (tx === fr[s]) ok++;
        if (ready_out === 1'b0) busy++;
        if (c == CLKS/2) mid[s] = tx;
        @(negedge clk);
      end
      chk($sformatf("%s_slot%0d", tag, s), ok, CLKS);
    end
    chk({tag, "_busy"}, busy, NB*CLKS);
  endtask

  // Receiver model: samples mid-bit starting from the first start-bit cycle.
  task automatic rx_model(output logic [7:0] b, output bit good);
    good = 1'b1;
    b    = '0;
    repeat (CLKS/2) @(negedge clk);
    if (tx !== 1'b0) good = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CLKS) @(negedge clk);
      b[i] = tx;
    end
    repeat (PB*CLKS) @(negedge clk);
    repeat (CLKS) @(negedge clk);
    if (tx !== 1'b1) good = 1'b0;
    wait_ready();
  endtask

  logic [11:0] mid;
  logic [7:0]  rxb;
  bit          rxok;
  int          cnt;
  logic [7:0]  lb [3];

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", ready_out, 0);
    rst = 1'b0;
    #1;
    chk("rel_ready_before_edge", ready_out, 0);
    @(negedge clk);
    chk("rel_ready_after_edge", ready_out, 1);
    chk("rel_tx_idle", tx, 1);

    // Single frame 0xA5
    start_tx(8'hA5, 1'b0);
    capture(build_frame(8'hA5), "a5", mid);
`ifdef UART_TX_PARITY_EN
    chk("a5_bits", int'(mid[10:0]), int'(11'b10101001010));
    chk("a5_parity_slot9", mid[9], 0);
`else
    chk("a5_bits", int'(mid[9:0]), int'(10'b1101001010));
`endif
    chk("a5_idle_ready", ready_out, 1);
    chk("a5_idle_tx", tx, 1);

`ifdef UART_TX_PARITY_EN
    start_tx(8'h07, 1'b0);
    capture(build_frame(8'h07), "p07", mid);
    chk("p07_parity_slot9", mid[9], 1);
`endif

    // Back-to-back 0x00 then 0xFF with valid_in held high
    start_tx(8'h00, 1'b1);
    data_in = 8'hFF;
    capture(build_frame(8'h00), "b2b0", mid);
    chk("b2b_gap_tx", tx, 1);
    chk("b2b_gap_ready", ready_out, 1);
    @(negedge clk);
    capture(build_frame(8'hFF), "b2b1", mid);
    chk("b2b_end_ready", ready_out, 1);
    valid_in = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b1 && ready_out === 1'b1) cnt++;
    end
    chk("b2b_no_third", cnt, 20);

    // Reset during data bit 3 of 0x5A
    start_tx(8'h5A, 1'b0);
    repeat (4*CLKS + 5) @(negedge clk);
    chk("mid_bit3_level", tx, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_ready", ready_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_ready_before_edge", ready_out, 0);
    @(negedge clk);
    chk("mid_rel_ready", ready_out, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (tx === 1'b1 && ready_out === 1'b1) cnt++;
      @(negedge clk);
    end
    chk("mid_no_residual", cnt, 40);

    // data_in changes after acceptance
    start_tx(8'h3C, 1'b0);
    data_in = 8'hC3;
    capture(build_frame(8'h3C), "hold3c", mid);
    chk("hold3c_data", int'(mid[8:1]), 8'h3C);

    // Loopback through the receiver model
    lb[0] = 8'h00;
    lb[1] = 8'h55;
    lb[2] = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      start_tx(lb[k], 1'b0);
      rx_model(rxb, rxok);
      chk($sformatf("loop%0d_valid", k), rxok, 1);
      chk($sformatf("loop%0d_data", k), rxb, lb[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
